song_sequencer: RTL and testbench

Controller that walks the song ROM note by note and drives the note player. It fetches 16-bit entries of the selected 32-note song, decodes note and duration, and pulses `new_note`. It times each note against the 48 Hz `beat` strobe, then advances. It handles play/pause, song selection, end-of-song detection and the ROM's one-cycle registered read latency.

---
 rtl/song_pkg.sv | 15 +
 rtl/song_sequencer_duration_timer.sv | 26 ++
 rtl/song_sequencer.sv | 124 ++++++++++++
 tb/tb_song_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared encodings for the song sequencer: FSM states, ROM entry field positions
// and song geometry.
package song_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, END, DONE} state_t;

  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int NOTE_W   = NOTE_MSB - NOTE_LSB + 1;
  localparam int DUR_W    = DUR_MSB - DUR_LSB + 1;

  localparam int               SONG_LEN     = 32;
  localparam logic [DUR_W-1:0] END_DURATION = '0;
endpackage

// File: rtl/song_sequencer_duration_timer.sv
// Beat-driven note duration counter: loads a duration, counts down on enabled
// beats and flags the beat that takes it to zero.
module duration_timer
  import song_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             beat,
  input  logic             enable,
  output logic [DUR_W-1:0] cnt,
  output logic             expired
);
  logic dec;

  // Only decrements while nonzero, so the counter can never wrap.
  assign dec     = enable && beat && (cnt != '0);
  assign expired = dec && (cnt == DUR_W'(1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/song_sequencer.sv
// Song ROM walker driving the note player. Define SONG_LOOP_EN to make songs
// repeat forever instead of stopping in DONE.
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_BITS     = 2,
  parameter int NOTE_IDX_BITS = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play,
  input  logic [SONG_BITS-1:0]               song,
  input  logic                               beat,
  output logic [SONG_BITS+NOTE_IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                        rom_dout,
  output logic                               new_note,
  output logic [NOTE_W-1:0]                  note,
  output logic                               note_active,
  output logic                               song_done,
  output logic                               playing
);
  state_t                   state, state_nxt;
  logic [SONG_BITS-1:0]     song_q, song_nxt;
  logic [NOTE_IDX_BITS-1:0] note_idx, idx_nxt;
  logic [NOTE_W-1:0]        note_nxt, rom_note;
  logic [DUR_W-1:0]         dur_cnt, rom_dur;
  logic new_note_nxt, song_done_nxt, song_chg, load, expired, last_note, timer_en;
  logic unused_rom_bits;

  assign rom_note        = rom_dout[NOTE_MSB:NOTE_LSB];
  assign rom_dur         = rom_dout[DUR_MSB:DUR_LSB];
  assign unused_rom_bits = ^{rom_dout[NOTE_MSB+1], rom_dout[DUR_LSB-1:0]};

  assign rom_addr    = {song_q, note_idx};
  assign song_chg    = (state != IDLE) && (song != song_q);
  assign last_note   = (note_idx == NOTE_IDX_BITS'(SONG_LEN - 1));
  assign playing     = (state != IDLE) && (state != DONE);
  assign note_active = (state == PLAY) && play && (note != '0);
  // The beat coinciding with new_note is dropped so the full duration is heard.
  assign timer_en    = (state == PLAY) && play && !new_note && !song_chg;

  duration_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (rom_dur),
    .beat     (beat),
    .enable   (timer_en),
    .cnt      (dur_cnt),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      song_q    <= '0;
      note_idx  <= '0;
      note      <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      song_q    <= song_nxt;
      note_idx  <= idx_nxt;
      note      <= note_nxt;
      new_note  <= new_note_nxt;
      song_done <= song_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    song_nxt      = song_q;
    idx_nxt       = note_idx;
    note_nxt      = note;
    new_note_nxt  = 1'b0;
    song_done_nxt = 1'b0;
    load          = 1'b0;
    // A song change overrides beat, end-of-song and play handling.
    if (song_chg) begin
      state_nxt = FETCH;
      song_nxt  = song;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (play) begin
          state_nxt = FETCH;
          song_nxt  = song;
          idx_nxt   = '0;
        end
        FETCH: state_nxt = WAIT;
        WAIT: begin
          if (rom_dur == END_DURATION) begin
            state_nxt = END;
          end else begin
            state_nxt    = PLAY;
            load         = 1'b1;
            note_nxt     = rom_note;
            new_note_nxt = 1'b1;
          end
        end
        PLAY: if (expired) begin
          if (last_note) begin
            state_nxt = END;
          end else begin
            state_nxt = FETCH;
            idx_nxt   = note_idx + 1'b1;
          end
        end
        END: begin
          song_done_nxt = 1'b1;
`ifdef SONG_LOOP_EN
          state_nxt = FETCH;
          idx_nxt   = '0;
`else
          state_nxt = DONE;
`endif
        end
        DONE: if (!play) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a per-cycle vector table for the first notes
// of song 0, then hand-written end-of-song, wrap, pause and song-change sequences.
module tb_song_sequencer;
  logic        clk = 1'b0;
  logic        reset, play, beat;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout = '0;
  logic        new_note, note_active, song_done, playing;
  logic [5:0]  note;
  logic [15:0] rom_mem [128];

  int vecs_applied = 0;
  int miscompares  = 0;
  int overlap      = 0;

  typedef struct {
    logic       rst, ply;
    logic [1:0] sng;
    logic       bt;
    logic       nn;
    logic [5:0] nt;
    logic       act, sd, pl;
    logic [6:0] addr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  song_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .play        (play),
    .song        (song),
    .beat        (beat),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .new_note    (new_note),
    .note        (note),
    .note_active (note_active),
    .song_done   (song_done),
    .playing     (playing)
  );

  function automatic logic [15:0] ent(input logic [5:0] n, input logic [5:0] d);
    return {1'b0, n, d, 3'b000};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    if (new_note && song_done) overlap++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic p, input logic [1:0] s, input logic b,
                     input logic nn, input logic [5:0] n, input logic a, input logic sd,
                     input logic pl, input logic [6:0] ad);
    vecs.push_back('{r, p, s, b, nn, n, a, sd, pl, ad});
  endtask

  task automatic start(input logic [1:0] s);
    reset = 1'b1; play = 1'b0; beat = 1'b0; song = s;
    step();
    reset = 1'b0; play = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   nn, bad, sd_cnt;
    logic hit;
    reset = 1'b1; play = 1'b0; beat = 1'b0; song = 2'd0;

    // song 0: 49/12, 1/3, rest/2, 13..37/1, end marker at 28
    for (int i = 0; i < 128; i++) rom_mem[i] = ent(6'd9, 6'd1);
    rom_mem[0] = ent(6'd49, 6'd12);
    rom_mem[1] = ent(6'd1, 6'd3);
    rom_mem[2] = ent(6'd0, 6'd2);
    for (int i = 3; i < 28; i++) rom_mem[i] = ent(6'(10 + i), 6'd1);
    rom_mem[28] = ent(6'd5, 6'd0);
    for (int i = 32; i < 64; i++) rom_mem[i] = ent(6'd20, 6'd30);
    rom_mem[32] = ent(6'd33, 6'd18);
    for (int i = 64; i < 96; i++) rom_mem[i] = ent(6'd7, 6'd2);
    rom_mem[64] = ent(6'd40, 6'd4);
    // song 3: every entry playable, reserved bits set to show they are ignored
    for (int i = 0; i < 32; i++) rom_mem[96 + i] = ent(6'(i + 1), 6'd1) | 16'h8005;

    //  rst ply sng bt | nn note act sd pl addr
    add(1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0,  0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0,  1, 49, 1, 0, 1, 0);
    add(0, 1, 0, 1,  0, 49, 1, 0, 1, 0);
    for (int i = 0; i < 11; i++) add(0, 1, 0, 1, 0, 49, 1, 0, 1, 0);
    add(0, 1, 0, 1,  0, 49, 0, 0, 1, 1);
    add(0, 1, 0, 0,  0, 49, 0, 0, 1, 1);
    add(0, 1, 0, 0,  1,  1, 1, 0, 1, 1);
    add(0, 1, 0, 1,  0,  1, 1, 0, 1, 1);
    add(0, 1, 0, 1,  0,  1, 1, 0, 1, 1);
    add(0, 1, 0, 1,  0,  1, 1, 0, 1, 1);
    add(0, 1, 0, 1,  0,  1, 0, 0, 1, 2);
    add(0, 1, 0, 0,  0,  1, 0, 0, 1, 2);
    add(0, 1, 0, 0,  1,  0, 0, 0, 1, 2);
    add(0, 1, 0, 0,  0,  0, 0, 0, 1, 2);
    add(0, 0, 0, 1,  0,  0, 0, 0, 1, 2);
    add(0, 1, 0, 1,  0,  0, 0, 0, 1, 2);
    add(0, 1, 0, 1,  0,  0, 0, 0, 1, 3);
    add(0, 1, 0, 0,  0,  0, 0, 0, 1, 3);
    add(0, 1, 0, 0,  1, 13, 1, 0, 1, 3);
    add(1, 1, 0, 1,  0,  0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; play = vecs[i].ply; song = vecs[i].sng; beat = vecs[i].bt;
      step();
      chk($sformatf("vec%0d", i),
          32'({new_note, note, note_active, song_done, playing, rom_addr}),
          32'({vecs[i].nn, vecs[i].nt, vecs[i].act, vecs[i].sd, vecs[i].pl, vecs[i].addr}));
    end

    // end-of-song marker at entry 28
    start(2'd0); beat = 1'b1; nn = 0; hit = 1'b0;
    for (int c = 0; c < 600 && !hit; c++) begin
      step();
      if (new_note) nn++;
      if (song_done) hit = 1'b1;
    end
    chk("end_done", 32'(hit), 32'd1);
    chk("end_notes", nn, 28);
`ifdef SONG_LOOP_EN
    chk("loop_playing", 32'(playing), 32'd1);
    step(); step();
    chk("loop_restart", 32'({new_note, note, playing}), 32'({1'b1, 6'd49, 1'b1}));
`else
    chk("end_playing", 32'(playing), 32'd0);
    chk("end_note_hold", 32'(note), 32'd37);
    step(); step(); step();
    chk("done_hold", 32'({new_note, song_done, playing, note}), 32'({3'b000, 6'd37}));
    play = 1'b0; step();
    play = 1'b1; step();
    chk("restart", 32'({playing, rom_addr}), 32'({1'b1, 7'd0}));
`endif

    // song 3 runs to the end through index 31
    start(2'd3); beat = 1'b1; nn = 0; hit = 1'b0; bad = 0;
    for (int c = 0; c < 800 && !hit; c++) begin
      step();
      if (playing && rom_addr < 7'd96) bad++;
      if (new_note) nn++;
      if (song_done) hit = 1'b1;
    end
    chk("wrap_done", 32'(hit), 32'd1);
    chk("wrap_notes", nn, 32);
    chk("wrap_addr", bad, 0);
    chk("wrap_last_note", 32'(note), 32'd32);

    // pause mid-note, duration 18
    start(2'd1); hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      step();
      if (new_note) hit = 1'b1;
    end
    chk("pause_nn", 32'({hit, note}), 32'({1'b1, 6'd33}));
    beat = 1'b1; step();
    chk("pause_load", 32'(dut.dur_cnt), 32'd18);
    for (int i = 0; i < 5; i++) begin beat = 1'b1; step(); beat = 1'b0; step(); end
    chk("pause_cnt5", 32'(dut.dur_cnt), 32'd13);
    play = 1'b0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      beat = 1'b1; step();
      if (note_active || new_note || !playing) bad++;
      beat = 1'b0; step();
    end
    chk("pause_frozen", 32'(dut.dur_cnt), 32'd13);
    chk("pause_quiet", bad, 0);
    chk("pause_note_hold", 32'(note), 32'd33);
    play = 1'b1; step();
    chk("resume_active", 32'(note_active), 32'd1);
    for (int i = 0; i < 12; i++) begin beat = 1'b1; step(); beat = 1'b0; step(); end
    chk("resume_cnt12", 32'({note_active, dut.dur_cnt}), 32'({1'b1, 6'd1}));
    beat = 1'b1; step(); beat = 1'b0;
    chk("resume_end", 32'({note_active, rom_addr}), 32'({1'b0, 7'd33}));
    step(); step();
    chk("next_nn", 32'({new_note, note}), 32'({1'b1, 6'd20}));

    // song change 1 -> 2 mid-note, with a coincident beat
    sd_cnt = 0;
    for (int i = 0; i < 3; i++) begin beat = 1'b1; step(); if (song_done) sd_cnt++; end
    song = 2'd2; step();
    if (song_done) sd_cnt++;
    chk("chg_addr", 32'({rom_addr, new_note}), 32'({7'd64, 1'b0}));
    step(); if (song_done) sd_cnt++;
    step(); if (song_done) sd_cnt++;
    chk("chg_nn", 32'({new_note, note}), 32'({1'b1, 6'd40}));
    chk("chg_no_done", sd_cnt, 0);

    chk("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
    $finish;
  end
endmodule
